model2axis_if: RTL

MODEL2AXIS_IF -- requirements
Module: model2axis_if

---
 rtl/model_if_pkg.sv | 12 +
 rtl/rsp_sync_fifo.sv | 43 ++++
 rtl/model2axis_if.sv | 115 +++++++++++
 3 files changed

// File: rtl/model_if_pkg.sv
// model_if_pkg: opcodes and state type shared by the model-side interface blocks.
package model_if_pkg;

    localparam logic [7:0] OP_CMD_HDR = 8'h80;
    localparam logic [7:0] OP_CMD_WR  = 8'h02;
    localparam logic [7:0] OP_CMD_RD  = 8'h03;
    localparam logic [7:0] OP_RSP_HDR = 8'h81;
    localparam logic [7:0] OP_RSP     = 8'h04;

    typedef enum logic [1:0] {IDLE, HDR, DATA} rsp_state_t;

endpackage

// File: rtl/rsp_sync_fifo.sv
// rsp_sync_fifo: single-clock FIFO with show-ahead head word, full/empty flags and occupancy count.
module rsp_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr] <= wr_data;

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end

endmodule

// File: rtl/model2axis_if.sv
// model2axis_if: buffers model response words and frames them as header+data AXI-stream packets.
// Optional idle-flush timer enabled by defining MODEL2AXIS_TIMEOUT_EN.
module model2axis_if
    import model_if_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic [31:0] dut_data,
    input  logic        dut_valid,
    output logic        dut_ready,
    input  logic        rsp_flush,
    output logic [31:0] core2gtp_tdata,
    output logic        core2gtp_tvalid,
    input  logic        core2gtp_tready,
    output logic        core2gtp_tlast,
    output logic        ovf_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 4");
    end
    if (MAX_BURST < 1 || MAX_BURST > FIFO_DEPTH) begin : g_bad_burst
        $error("MAX_BURST must be in 1..FIFO_DEPTH");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    rsp_state_t    state;
    logic [CW-1:0] count, burst_len, beat, len_now;
    logic [31:0]   head;
    logic          full, empty, push, pop, flush_q, timeout_hit, start;

    assign dut_ready = !full;
    assign push      = dut_valid && !full;
    // Head is loaded into the output register on acceptance of the previous beat, so pop happens then.
    assign pop       = core2gtp_tready && (state == HDR || (state == DATA && !core2gtp_tlast));
    assign len_now   = count >= CW'(MAX_BURST) ? CW'(MAX_BURST) : count;
    assign start     = state == IDLE &&
                       (count >= CW'(MAX_BURST) || (flush_q && !empty) || timeout_hit);

    rsp_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk     (core_clk),
        .rst_n   (rst_n),
        .wr_en   (dut_valid),
        .wr_data (dut_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

`ifdef MODEL2AXIS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] timer;

    always_ff @(posedge core_clk or negedge rst_n)
        if (!rst_n) timer <= '0;
        else        timer <= (state != IDLE || push || start) ? '0 : (!empty ? timer + 1'b1 : timer);

    assign timeout_hit = !empty && timer == TW'(TIMEOUT - 1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge core_clk or negedge rst_n)
        if (!rst_n) begin
            state           <= IDLE;
            burst_len       <= '0;
            beat            <= '0;
            flush_q         <= 1'b0;
            ovf_err         <= 1'b0;
            core2gtp_tdata  <= '0;
            core2gtp_tvalid <= 1'b0;
            core2gtp_tlast  <= 1'b0;
        end else begin
            flush_q <= rsp_flush && state == IDLE;
            if (dut_valid && full) ovf_err <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state           <= HDR;
                    burst_len       <= len_now;
                    core2gtp_tdata  <= {OP_RSP_HDR, 8'h00, 16'(len_now)};
                    core2gtp_tvalid <= 1'b1;
                    core2gtp_tlast  <= 1'b0;
                end
                HDR: if (core2gtp_tready) begin
                    state          <= DATA;
                    beat           <= CW'(1);
                    core2gtp_tdata <= head;
                    core2gtp_tlast <= burst_len == CW'(1);
                end
                DATA: if (core2gtp_tready) begin
                    if (core2gtp_tlast) begin
                        state           <= IDLE;
                        core2gtp_tdata  <= '0;
                        core2gtp_tvalid <= 1'b0;
                        core2gtp_tlast  <= 1'b0;
                    end else begin
                        beat           <= beat + CW'(1);
                        core2gtp_tdata <= head;
                        core2gtp_tlast <= (beat + CW'(1)) == burst_len;
                    end
                end
                default: state <= IDLE;
            endcase
        end

endmodule
